// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed, double-buffered hex digit scanner feeding a 7-segment decoder
// Optional feature macro: SEG7_SCAN_LZB_EN (leading-zero blanking)
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   value       new hex value, digit k = value[4k+3:4k]
//   load        1-cycle strobe capturing value into the pending buffer
//   blank       per-digit live force-off mask (1 = anode off)
//   digit       nibble of the selected digit
//   an          active-low anode select, at most one bit low
//   frame_start 1-cycle pulse when the scan returns to digit 0
module seg7_scan #(
    parameter int NDIGITS = 4,
    parameter int DIV     = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    input  logic [NDIGITS-1:0]     blank,
    output logic [3:0]             digit,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_start
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIGITS);
    localparam int W  = 4 * NDIGITS;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx, nidx;
    logic [W-1:0]       pend, disp, disp_nx;
    logic [NDIGITS-1:0] sel, sel_nx, lz;
    logic               tick, last, fb;
    // sel is the unblanked scan pattern; an re-applies blank every cycle so it acts live
    always_comb begin
        tick    = cnt == CW'(DIV - 1);
        last    = idx == IW'(NDIGITS - 1);
        fb      = tick && last;
        nidx    = last ? '0 : idx + 1'b1;
        disp_nx = fb ? (load ? value : pend) : disp;
        sel_nx  = tick ? ~(NDIGITS'(1) << nidx) : sel;
    end
`ifdef SEG7_SCAN_LZB_EN
    // digit k is a leading zero when it and every more significant nibble are zero
    always_comb begin
        lz = '0;
        for (int k = 1; k < NDIGITS; k++)
            lz[k] = (disp_nx >> (4 * k)) == '0;
    end
`else
    assign lz = '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= IW'(NDIGITS - 1);
            pend        <= '0;
            disp        <= '0;
            sel         <= '1;
            an          <= '1;
            digit       <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= nidx;
            if (load) pend <= value;
            disp        <= disp_nx;
            sel         <= sel_nx;
            an          <= sel_nx | blank | lz;
            if (tick) digit <= disp_nx[{nidx, 2'b00} +: 4];
            frame_start <= fb;
        end
    end
endmodule
